// File: rtl/seg_scan_driver_if.sv
// Display-stage bundle: ALU result and op select in,
// multiplexed segment/anode drive and converter status out.
interface seg_scan_driver_if;
  logic [7:0] value;
  logic [3:0] op_sel;
  logic [6:0] seg;
  logic [3:0] an;
  logic       conv_busy;

  modport master (
    output value, op_sel,
    input  seg, an, conv_busy
  );

  modport slave (
    input  value, op_sel,
    output seg, an, conv_busy
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Clocked 4-digit display stage: double-dabble BCD of value,
// leading-zero blanking, time-multiplexed common-anode scan.
// Ports: clk, reset (sync, active-high), bus (slave modport):
//   value/op_sel in; seg/an active-low, conv_busy out.
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  seg_scan_driver_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  shown;
  logic [7:0]  cap;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic [2:0]  bit_cnt;
  logic        busy;

  logic [3:0]  hun;
  logic [3:0]  ten;
  logic [3:0]  uni;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [6:0]    seg_q;
  logic [3:0]    an_q;

  logic [3:0]  u_adj;
  logic [3:0]  t_adj;
  logic [6:0]  seg_nx;
  logic [3:0]  an_nx;

  function automatic logic [6:0] hex_seg(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h7F;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] bcd_seg(input logic [3:0] d);
    return (d > 4'd9) ? 7'h7F : hex_seg(d);
  endfunction

  // Hundreds is at most 1 before any shift, so it never needs +3.
  always_comb begin
    u_adj = bcd[3:0];
    t_adj = bcd[7:4];
    if (bcd[3:0] >= 4'd5) u_adj = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) t_adj = bcd[7:4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shown   <= '0;
      cap     <= '0;
      bin     <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      hun     <= '0;
      ten     <= '0;
      uni     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.value != shown) begin
            cap     <= bus.value;
            bin     <= bus.value;
            bcd     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd     <= {bcd[10:8], t_adj, u_adj, bin[7]};
          bin     <= {bin[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          hun   <= bcd[11:8];
          ten   <= bcd[7:4];
          uni   <= bcd[3:0];
          shown <= cap;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    an_nx  = 4'hF;
    seg_nx = 7'h7F;
    unique case (1'b1)
      (idx == 2'd0): begin
        an_nx  = 4'b1110;
        seg_nx = bcd_seg(uni);
      end
      (idx == 2'd1): begin
        an_nx  = 4'b1101;
        seg_nx = (hun == 4'd0 && ten == 4'd0) ?
                 7'h7F : bcd_seg(ten);
      end
      (idx == 2'd2): begin
        an_nx  = 4'b1011;
        seg_nx = (hun == 4'd0) ? 7'h7F : bcd_seg(hun);
      end
      default: begin
        an_nx  = 4'b0111;
        seg_nx = hex_seg(bus.op_sel);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= 7'h7F;
      an_q  <= 4'hF;
    end else begin
      seg_q <= seg_nx;
      an_q  <= an_nx;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.conv_busy = busy;

endmodule
